// File: rtl/fetch_sequencer_if.sv
// ============================================================================
// Module   : fetch_sequencer_if
// Brief    : Instruction-memory, decode and redirect signals for fetch_sequencer
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fetch_sequencer_if #(
    parameter int PC_WIDTH = 32
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_ack;
    logic [31:0]         imem_rdata;
    logic [31:0]         ir;
    logic [PC_WIDTH-1:0] ir_pc;
    logic                ir_valid;
    logic                dec_ready;
    logic                redirect;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                halted;

    // The fetch sequencer is the master; memory/decode/branch logic is the slave.
    modport master (
        output imem_req, imem_addr, ir, ir_pc, ir_valid, halted,
        input  imem_ack, imem_rdata, dec_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, ir, ir_pc, ir_valid, halted,
        output imem_ack, imem_rdata, dec_ready, redirect, redirect_pc
    );
endinterface

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module   : fetch_sequencer
// Brief    : Instruction fetch controller: PC, imem handshake, IR, redirect, halt
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_sequencer #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_sequencer_if.master   bus
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_FETCH = 3'd1;
    localparam logic [2:0] c_FLUSH = 3'd2;
    localparam logic [2:0] c_HOLD  = 3'd3;
    localparam logic [2:0] c_HALT  = 3'd4;

    localparam logic [31:0] c_NOP    = 32'h0000_0013;
    localparam logic [6:0]  c_SYSTEM = 7'b1110011;

    logic [2:0]          r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_addr;
    logic [31:0]         r_ir;
    logic [PC_WIDTH-1:0] r_ir_pc;

    logic [2:0]          w_state_next;
    logic [PC_WIDTH-1:0] w_pc_next;
    logic                w_load_ir;
    logic [PC_WIDTH-1:0] w_redirect_pc;

    assign w_redirect_pc = {bus.redirect_pc[PC_WIDTH-1:2], 2'b00};

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_ir    <= c_NOP;
            r_ir_pc <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            // In FLUSH the old request is still on the bus, so its address must hold.
            if (w_state_next != c_FLUSH) begin
                r_addr <= w_pc_next;
            end
            if (w_load_ir) begin
                r_ir    <= bus.imem_rdata;
                r_ir_pc <= r_pc;
            end
        end
    end

    // Next-state and next-PC decision
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_load_ir    = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_state_next = c_FETCH;
                if (bus.redirect) begin
                    w_pc_next = w_redirect_pc;
                end
            end
            c_FETCH: begin
                if (bus.redirect) begin
                    w_pc_next    = w_redirect_pc;
                    w_state_next = bus.imem_ack ? c_FETCH : c_FLUSH;
                end else if (bus.imem_ack) begin
                    w_load_ir    = 1'b1;
                    w_pc_next    = r_pc + PC_WIDTH'(4);
                    w_state_next = c_HOLD;
                end
            end
            c_FLUSH: begin
                if (bus.redirect) begin
                    w_pc_next = w_redirect_pc;
                end
                if (bus.imem_ack) begin
                    w_state_next = c_FETCH;
                end
            end
            c_HOLD: begin
                if (bus.redirect) begin
                    w_pc_next    = w_redirect_pc;
                    w_state_next = c_FETCH;
                end else if (bus.dec_ready) begin
                    w_state_next = (r_ir[6:0] == c_SYSTEM) ? c_HALT : c_FETCH;
                end
            end
            c_HALT: begin
                if (bus.redirect) begin
                    w_pc_next    = w_redirect_pc;
                    w_state_next = c_FETCH;
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        bus.imem_req  = (r_state == c_FETCH) || (r_state == c_FLUSH);
        bus.ir_valid  = (r_state == c_HOLD);
        bus.halted    = (r_state == c_HALT);
        bus.imem_addr = r_addr;
        bus.ir        = r_ir;
        bus.ir_pc     = r_ir_pc;
    end

endmodule

`default_nettype wire
